// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the configurable FIR slice.
//   fir_state_e : coefficient-bank state encoding (RUN=0, LOAD=1)
//   sum_width() : full-precision width of the tap sum
package fir_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } fir_state_e;

    // Product width plus enough guard bits to add NTAPS products without overflow.
    function automatic int unsigned sum_width(input int unsigned xw,
                                              input int unsigned cw,
                                              input int unsigned ntaps);
        return xw + cw + unsigned'($clog2(ntaps));
    endfunction

endpackage

// File: rtl/fir_pipe_cfg_if.sv
// fir_pipe_cfg_if: sample, coefficient-load and result signals of the FIR.
//   master : drives in_valid, x_n, flush, coef_start, coef_valid, coef_in
//   slave  : drives in_ready, coef_done, out_valid, y_n
interface fir_pipe_cfg_if #(
    parameter int unsigned XW = 6,
    parameter int unsigned CW = 4,
    parameter int unsigned YW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [XW-1:0] x_n;
    logic                 flush;
    logic                 coef_start;
    logic                 coef_valid;
    logic signed [CW-1:0] coef_in;
    logic                 coef_done;
    logic                 out_valid;
    logic signed [YW-1:0] y_n;

    modport master (
        output in_valid, x_n, flush, coef_start, coef_valid, coef_in,
        input  in_ready, coef_done, out_valid, y_n
    );

    modport slave (
        input  in_valid, x_n, flush, coef_start, coef_valid, coef_in,
        output in_ready, coef_done, out_valid, y_n
    );
endinterface

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: coefficient registers, load index and RUN/LOAD state.
//   clk, reset        : clock, synchronous active-high reset
//   coef_start        : (re)start a load at tap 0
//   coef_valid/coef_in: coefficient stream, tap 0 first (ignored in RUN)
//   coef              : current coefficients (reset to pass-through)
//   in_ready          : high in RUN, low while loading
//   coef_done         : one-cycle pulse after the last tap is written
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = 8,
    parameter int unsigned CW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coef_start,
    input  logic                 coef_valid,
    input  logic signed [CW-1:0] coef_in,
    output logic signed [CW-1:0] coef [NTAPS],
    output logic                 in_ready,
    output logic                 coef_done
);
    localparam int unsigned IW = $clog2(NTAPS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

    fir_state_e    state;
    logic [IW-1:0] idx;

    // Load FSM: coef_start always restarts at tap 0; the final write returns to RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            idx       <= '0;
            coef_done <= 1'b0;
            for (int unsigned k = 0; k < NTAPS; k++) begin
                coef[k] <= '0;
            end
            coef[0] <= CW'(1);
        end else begin
            coef_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (coef_start) begin
                        state <= ST_LOAD;
                        idx   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (coef_start) begin
                        idx <= '0;
                    end else if (coef_valid) begin
                        coef[idx] <= coef_in;
                        if (idx == LAST_IDX) begin
                            idx       <= '0;
                            coef_done <= 1'b1;
                            state     <= ST_RUN;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Decode of the one-bit state register.
    assign in_ready = (state == ST_RUN);

endmodule

// File: rtl/fir_pipe_cfg.sv
// fir_pipe_cfg: reloadable direct-form FIR, two-stage pipeline.
//   clk, reset : clock, synchronous active-high reset
//   bus        : sample input (in_valid/in_ready/x_n), flush, coefficient
//                load (coef_start/coef_valid/coef_in/coef_done) and the
//                saturated result (out_valid/y_n, 2 cycles after accept)
module fir_pipe_cfg
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = 8,
    parameter int unsigned XW    = 6,
    parameter int unsigned CW    = 4,
    parameter int unsigned YW    = 8,
    parameter int unsigned SHIFT = 0
) (
    input logic         clk,
    input logic         reset,
    fir_pipe_cfg_if.slave bus
);
    localparam int unsigned PW = XW + CW;
    localparam int unsigned SW = sum_width(XW, CW, NTAPS);
    localparam logic signed [SW-1:0] Y_MAX = SW'((2 ** (YW - 1)) - 1);
    localparam logic signed [SW-1:0] Y_MIN = ~Y_MAX;

    logic signed [CW-1:0] coef      [NTAPS];
    logic signed [XW-1:0] dline     [NTAPS];
    logic signed [XW-1:0] dline_nxt [NTAPS];
    logic signed [PW-1:0] prod_q    [NTAPS];
    logic signed [SW-1:0] sum_c;
    logic signed [SW-1:0] shifted_c;
    logic signed [YW-1:0] sat_c;
    logic                 accept;
    logic                 take;
    logic                 prod_valid;

    fir_coef_bank #(
        .NTAPS (NTAPS),
        .CW    (CW)
    ) u_coef_bank (
        .clk        (clk),
        .reset      (reset),
        .coef_start (bus.coef_start),
        .coef_valid (bus.coef_valid),
        .coef_in    (bus.coef_in),
        .coef       (coef),
        .in_ready   (bus.in_ready),
        .coef_done  (bus.coef_done)
    );

    assign accept = bus.in_valid && bus.in_ready;
    // A sample arriving with flush is dropped along with the history.
    assign take   = accept && !bus.flush;

    // Delay line contents as they will be after this accept.
    always_comb begin
        dline_nxt[0] = bus.x_n;
        for (int unsigned k = 1; k < NTAPS; k++) begin
            dline_nxt[k] = dline[k-1];
        end
    end

    // Full-precision sum, arithmetic shift, then clamp to the output range.
    always_comb begin
        sum_c = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            sum_c = sum_c + SW'(prod_q[k]);
        end
        shifted_c = sum_c >>> SHIFT;
        if (shifted_c > Y_MAX) begin
            sat_c = {1'b0, {(YW-1){1'b1}}};
        end else if (shifted_c < Y_MIN) begin
            sat_c = {1'b1, {(YW-1){1'b0}}};
        end else begin
            sat_c = YW'(shifted_c);
        end
    end

    // Delay line, multiply stage and sum stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                dline[k]  <= '0;
                prod_q[k] <= '0;
            end
            prod_valid    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.y_n       <= '0;
        end else begin
            if (bus.flush) begin
                for (int unsigned k = 0; k < NTAPS; k++) begin
                    dline[k] <= '0;
                end
            end else if (accept) begin
                for (int unsigned k = 0; k < NTAPS; k++) begin
                    dline[k] <= dline_nxt[k];
                end
            end

            prod_valid <= take;
            if (take) begin
                for (int unsigned k = 0; k < NTAPS; k++) begin
                    prod_q[k] <= PW'(coef[k]) * PW'(dline_nxt[k]);
                end
            end

            bus.out_valid <= prod_valid;
            if (prod_valid) begin
                bus.y_n <= sat_c;
            end
        end
    end

endmodule
